entrada_clave_teclado: RTL

- Producer side of the 8-bit access-code interface consumed by the parking access controller.
- Collects two BCD digits from the keypad scanner's key strobes and handles the clear and enter keys.
- Presents the assembled code with a valid/accept handshake and discards stale partial entries after a timeout.
- Sits between the keypad scanner and the access FSM.

---
 rtl/acceso_pkg.sv | 23 ++
 rtl/contador_inactividad.sv | 30 +++
 rtl/entrada_clave_teclado.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/acceso_pkg.sv
// Shared definitions for the access-code path: key codes, code/digit widths
// and the one-hot state encoding of the keypad entry FSM.
package acceso_pkg;

  localparam int unsigned ANCHO_CLAVE  = 8;
  localparam int unsigned ANCHO_DIGITO = 4;

  localparam logic [ANCHO_DIGITO-1:0] TECLA_MAX_DIGITO = 4'h9;
  localparam logic [ANCHO_DIGITO-1:0] TECLA_BORRAR     = 4'hA;
  localparam logic [ANCHO_DIGITO-1:0] TECLA_ENVIAR     = 4'hB;

  typedef enum logic [3:0] {
    ESPERA_DIGITO1 = 4'b0001,
    ESPERA_DIGITO2 = 4'b0010,
    ESPERA_ENVIAR  = 4'b0100,
    PRESENTANDO    = 4'b1000
  } estado_t;

  function automatic logic es_digito(input logic [ANCHO_DIGITO-1:0] codigo);
    return codigo <= TECLA_MAX_DIGITO;
  endfunction

endpackage

// File: rtl/contador_inactividad.sv
// Inactivity counter: synchronous clear has priority over enable; terminal
// flags the last cycle (TIMEOUT_CICLOS-1) while counting is enabled.
module contador_inactividad #(
  parameter int unsigned TIMEOUT_CICLOS = 1000,
  parameter int unsigned ANCHO_CONTADOR = $clog2(TIMEOUT_CICLOS+1)
) (
  input  logic clock,
  input  logic reset,
  input  logic limpiar,
  input  logic habilitar,
  output logic terminal
);

  localparam logic [ANCHO_CONTADOR-1:0] CUENTA_FINAL = ANCHO_CONTADOR'(TIMEOUT_CICLOS-1);

  logic [ANCHO_CONTADOR-1:0] cuenta;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cuenta <= '0;
    end else if (limpiar) begin
      cuenta <= '0;
    end else if (habilitar && (cuenta != CUENTA_FINAL)) begin
      cuenta <= cuenta + 1'b1;
    end
  end

  assign terminal = habilitar && (cuenta == CUENTA_FINAL);

endmodule

// File: rtl/entrada_clave_teclado.sv
// Keypad two-digit BCD code entry with valid/accept handshake and inactivity
// timeout. Define TIMEOUT_ACK_EN to also time out an unaccepted presentation.
module entrada_clave_teclado
  import acceso_pkg::*;
#(
  parameter int unsigned TIMEOUT_CICLOS = 1000,
  localparam int unsigned ANCHO_CONTADOR = $clog2(TIMEOUT_CICLOS+1)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tecla_valida,
  input  logic [3:0] tecla_codigo,
  input  logic       clave_aceptada,
  output logic [7:0] clave_ingresada,
  output logic       clave_valida,
  output logic [1:0] digitos_ingresados,
  output logic       error_entrada
);

  estado_t    estado, estado_sig;
  logic [7:0] clave_sig;
  logic       valida_sig;
  logic [1:0] digitos_sig;
  logic       error_sig;
  logic       borrar;
  logic       cont_limpiar, cont_habilitar, expira;

  contador_inactividad #(
    .TIMEOUT_CICLOS (TIMEOUT_CICLOS),
    .ANCHO_CONTADOR (ANCHO_CONTADOR)
  ) u_contador (
    .clock     (clock),
    .reset     (reset),
    .limpiar   (cont_limpiar),
    .habilitar (cont_habilitar),
    .terminal  (expira)
  );

  always_comb begin
`ifdef TIMEOUT_ACK_EN
    cont_habilitar = (estado == ESPERA_DIGITO2) || (estado == ESPERA_ENVIAR) ||
                     (estado == PRESENTANDO);
`else
    cont_habilitar = (estado == ESPERA_DIGITO2) || (estado == ESPERA_ENVIAR);
`endif
    // Keys are ignored while presenting, so they must not restart the accept timer.
    cont_limpiar = !cont_habilitar || (estado_sig != estado) ||
                   (tecla_valida && (estado != PRESENTANDO));
  end

  always_comb begin
    estado_sig  = estado;
    clave_sig   = clave_ingresada;
    valida_sig  = clave_valida;
    digitos_sig = digitos_ingresados;
    error_sig   = 1'b0;
    borrar      = 1'b0;

    case (estado)
      ESPERA_DIGITO1: begin
        if (tecla_valida) begin
          if (es_digito(tecla_codigo)) begin
            clave_sig   = {tecla_codigo, 4'h0};
            digitos_sig = 2'd1;
            estado_sig  = ESPERA_DIGITO2;
          end else if (tecla_codigo != TECLA_BORRAR) begin
            error_sig = 1'b1;
          end
        end
      end

      ESPERA_DIGITO2: begin
        if (tecla_valida) begin
          if (es_digito(tecla_codigo)) begin
            clave_sig[3:0] = tecla_codigo;
            digitos_sig    = 2'd2;
            estado_sig     = ESPERA_ENVIAR;
          end else if (tecla_codigo == TECLA_BORRAR) begin
            borrar = 1'b1;
          end else if (tecla_codigo == TECLA_ENVIAR) begin
            borrar    = 1'b1;
            error_sig = 1'b1;
          end else begin
            error_sig = 1'b1;
          end
        end else if (expira) begin
          borrar    = 1'b1;
          error_sig = 1'b1;
        end
      end

      ESPERA_ENVIAR: begin
        if (tecla_valida) begin
          if (tecla_codigo == TECLA_ENVIAR) begin
            valida_sig = 1'b1;
            estado_sig = PRESENTANDO;
          end else if (tecla_codigo == TECLA_BORRAR) begin
            borrar = 1'b1;
          end else begin
            error_sig = 1'b1;
          end
        end else if (expira) begin
          borrar    = 1'b1;
          error_sig = 1'b1;
        end
      end

      PRESENTANDO: begin
        if (clave_aceptada) begin
          borrar = 1'b1;
`ifdef TIMEOUT_ACK_EN
        end else if (expira) begin
          borrar    = 1'b1;
          error_sig = 1'b1;
`endif
        end
      end

      default: begin
        borrar = 1'b1;
      end
    endcase

    if (borrar) begin
      estado_sig  = ESPERA_DIGITO1;
      clave_sig   = '0;
      valida_sig  = 1'b0;
      digitos_sig = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado             <= ESPERA_DIGITO1;
      clave_ingresada    <= '0;
      clave_valida       <= 1'b0;
      digitos_ingresados <= '0;
      error_entrada      <= 1'b0;
    end else begin
      estado             <= estado_sig;
      clave_ingresada    <= clave_sig;
      clave_valida       <= valida_sig;
      digitos_ingresados <= digitos_sig;
      error_entrada      <= error_sig;
    end
  end

endmodule
